// File: rtl/mult_div_unit_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// Carries operands, op select, D-stage hazard input, and HI/LO/Out/Busy/Stall.
interface mult_div_unit_if;
  logic        Start;
  logic [3:0]  MdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        IsMdD;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output Start, MdOp, A, B, IsMdD,
    input  Busy, Stall, HI, LO, Out
  );

  modport slave (
    input  Start, MdOp, A, B, IsMdD,
    output Busy, Stall, HI, LO, Out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu unit holding HI/LO, serving mfhi/mflo/mthi/mtlo.
// Ports: clk, reset (sync, active-high), md (slave: Start/MdOp/A/B/IsMdD in; Busy/Stall/HI/LO/Out out).
module mult_div_unit #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q, phi_q, plo_q;
  logic        busy, is_arith, is_mul, is_signed;
  logic        launch, commit, mt_hi, mt_lo;
  logic [63:0] a_ext, b_ext, prod, res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  assign busy     = (state_q == RUN);
  assign is_arith = md.Start && (md.MdOp >= OP_MULT) && (md.MdOp <= OP_DIVU);
  assign is_mul   = (md.MdOp == OP_MULT) || (md.MdOp == OP_MULTU);
  assign is_signed = (md.MdOp == OP_MULT) || (md.MdOp == OP_DIV);
  assign launch   = is_arith && !busy;
  assign mt_hi    = md.Start && (md.MdOp == OP_MTHI) && !busy;
  assign mt_lo    = md.Start && (md.MdOp == OP_MTLO) && !busy;

  // Divide on magnitudes and fix signs afterwards; this also makes
  // 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
  always_comb begin
    a_ext = is_signed ? {{32{md.A[31]}}, md.A} : {32'b0, md.A};
    b_ext = is_signed ? {{32{md.B[31]}}, md.B} : {32'b0, md.B};
    prod  = a_ext * b_ext;
    a_neg = is_signed && md.A[31];
    b_neg = is_signed && md.B[31];
    a_mag = a_neg ? -md.A : md.A;
    b_mag = b_neg ? -md.B : md.B;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    if (is_mul) begin
      res = prod;
    end else if (md.B == '0) begin
      // Divide by zero: commit rewrites the current HI/LO.
      res = {hi_q, lo_q};
    end else begin
      res = {a_neg ? -r_mag : r_mag,
             (a_neg ^ b_neg) ? -q_mag : q_mag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = RUN;
          cnt_d   = is_mul ? 4'(MultCycles) : 4'(DivCycles);
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
    end else begin
      if (launch) begin
        phi_q <= res[63:32];
        plo_q <= res[31:0];
      end
      if (commit) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end else begin
        if (mt_hi) hi_q <= md.A;
        if (mt_lo) lo_q <= md.A;
      end
    end
  end

  assign md.Busy  = busy;
  assign md.Stall = md.IsMdD && (busy || is_arith);
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

  always_comb begin
    md.Out = '0;
    if (md.MdOp == OP_MFHI) md.Out = hi_q;
    if (md.MdOp == OP_MFLO) md.Out = lo_q;
  end

endmodule
